// File: rtl/apb_stream_pkg.sv
// apb_stream_pkg: register map, CTRL/STATUS bit positions and FSM states shared by apb_stream_source
package apb_stream_pkg;
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LEN    = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_ABORTED  = 2;
  localparam int ST_CNT_LSB  = 16;
  localparam int MAX_LEN     = 1024;
  typedef enum logic [1:0] {IDLE, PRIME, SEND, DRAIN} state_t;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: one write port and two registered read ports over a shared word array
//   we/waddr/wdata : write port
//   a_addr/a_data_q: read port A, data one cycle after the address
//   b_addr/b_data_q: read port B, data one cycle after the address
module sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data_q,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data_q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    a_data_q <= mem[a_addr];
    b_data_q <= mem[b_addr];
  end
endmodule

// File: rtl/apb_stream_source.sv
// apb_stream_source: APB-filled word buffer replayed as an AXI-Stream frame
//   S_APB_*  : APB slave; paddr[12]=0 buffer words, paddr[12]=1 CTRL/LEN/STATUS
//   M_AXIS_* : stream master emitting words 0..LEN-1 with tlast on the final beat
module apb_stream_source
  import apb_stream_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              S_APB_aclk,
  input  logic              S_APB_aresetn,
  input  logic [31:0]       S_APB_paddr,
  input  logic              S_APB_psel,
  input  logic              S_APB_penable,
  input  logic              S_APB_pwrite,
  input  logic [31:0]       S_APB_pwdata,
  output logic [31:0]       S_APB_prdata,
  output logic              S_APB_pready,
  output logic              S_APB_pslverr,
  output logic [DATA_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  output logic [3:0]        M_AXIS_tkeep,
  output logic              M_AXIS_tlast,
  input  logic              M_AXIS_tready
);
  localparam int LW = ADDR_W + 1;
  state_t state_q, state_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d, rd_buf_q, rd_buf_d;
  logic done_q, done_d, aborted_q, aborted_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic [LW-1:0] len_q, len_d, ptr_q, ptr_d, cnt_q, cnt_d;
  logic access, wr, is_reg, busy, start, abort, hs, ram_we, tvalid, stop_ab;
  logic [1:0] off;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ram_a, ram_b;
  logic unused_addr;
  assign unused_addr = &{1'b0, S_APB_paddr[31:13], S_APB_paddr[1:0]};
  assign tvalid = state_q == SEND || state_q == DRAIN;
  assign hs = tvalid && M_AXIS_tready;
  assign M_AXIS_tvalid = tvalid;
  assign M_AXIS_tlast = tvalid && ptr_q == len_q - LW'(1);
  assign M_AXIS_tdata = tvalid ? ram_b : '0;
  assign M_AXIS_tkeep = 4'hF;
  assign S_APB_pready = pready_q;
  assign S_APB_pslverr = pslverr_q;
  assign S_APB_prdata = !pready_q ? '0 : rd_buf_q ? 32'(ram_a) : rdata_q;
  // Re-reading ptr while stalled keeps tdata stable; the buffer cannot change mid-frame.
  assign rb_addr = hs ? ptr_q[ADDR_W-1:0] + ADDR_W'(1) : ptr_q[ADDR_W-1:0];
  sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk      (S_APB_aclk),
    .we       (ram_we),
    .waddr    (S_APB_paddr[ADDR_W+1:2]),
    .wdata    (DATA_W'(S_APB_pwdata)),
    .a_addr   (S_APB_paddr[ADDR_W+1:2]),
    .a_data_q (ram_a),
    .b_addr   (rb_addr),
    .b_data_q (ram_b)
  );
  always_comb begin
    access = S_APB_psel && S_APB_penable && !pready_q;
    wr = access && S_APB_pwrite;
    is_reg = S_APB_paddr[12];
    off = S_APB_paddr[3:2];
    busy = state_q != IDLE;
    start = wr && is_reg && off == OFF_CTRL && S_APB_pwdata[CTRL_START];
    abort = wr && is_reg && off == OFF_CTRL && S_APB_pwdata[CTRL_ABORT];
    ram_we = wr && !is_reg && !busy;
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_ABORTED] = aborted_q;
    status[ST_CNT_LSB +: LW] = cnt_q;
    pready_d = access;
    pslverr_d = wr && !is_reg && busy;
    rd_buf_d = !is_reg;
    rdata_d = off == OFF_LEN ? 32'(len_q) : off == OFF_STATUS ? status : '0;
    len_d = wr && is_reg && off == OFF_LEN && !busy
          ? (S_APB_pwdata > 32'(MAX_LEN) ? LW'(MAX_LEN) : S_APB_pwdata[LW-1:0]) : len_q;
    stop_ab = abort || state_q == DRAIN;
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    done_d = done_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: if (start && len_q != '0) begin
        state_d = PRIME;
        ptr_d = '0;
        cnt_d = '0;
        done_d = 1'b0;
        aborted_d = 1'b0;
      end
      PRIME: begin
        state_d = abort ? IDLE : SEND;
        aborted_d = abort;
      end
      default: begin
        ptr_d = hs ? ptr_q + LW'(1) : ptr_q;
        cnt_d = hs ? cnt_q + LW'(1) : cnt_q;
        // An accepted beat ends the frame if it was last or an abort is pending/arriving.
        if (hs && (stop_ab || M_AXIS_tlast)) begin
          state_d = IDLE;
          aborted_d = stop_ab;
          done_d = !stop_ab;
        end else if (abort) state_d = DRAIN;
      end
    endcase
  end
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn)
    if (!S_APB_aresetn) begin
      state_q <= IDLE;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      rd_buf_q <= 1'b0;
      rdata_q <= '0;
      len_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      rd_buf_q <= rd_buf_d;
      rdata_q <= rdata_d;
      len_q <= len_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      aborted_q <= aborted_d;
    end
endmodule
